ir_loader: RTL and testbench
============================

IR_LOADER -- requirements
Module: ir_loader

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of the memory data word, the memory address and the instruction word.
REQ-002 The block SHALL have parameter IR_ADDR_WIDTH, default 8, giving the width of the instruction-register-file address and of the load length.
REQ-003 The block SHALL have parameter LOAD_BASE, default 0, giving the first memory address to load from.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset; it is synchronous and active-low.
REQ-006 The block SHALL have port i_start, input, 1, a load-start request sampled in IDLE or DONE.
REQ-007 The block SHALL have port i_length, input, IR_ADDR_WIDTH, the number of words to load, sampled with i_start.
REQ-008 The block SHALL have port o_mem_req, output, 1, the memory read request.
REQ-009 The block SHALL have port o_mem_addr, output, DATA_WIDTH, the memory read address.
REQ-010 The block SHALL have port i_mem_ack, input, 1, the memory acknowledge; i_mem_data is valid in the same cycle.
REQ-011 The block SHALL have port i_mem_data, input, DATA_WIDTH, the memory read data.
REQ-012 The block SHALL have port o_ir_we, output, 1, the write strobe to the instruction register file.
REQ-013 The block SHALL have port o_ir_addr, output, IR_ADDR_WIDTH, the instruction register file write address.
REQ-014 The block SHALL have port o_ir_data, output, DATA_WIDTH, the instruction register file write data.
REQ-015 The block SHALL have port o_busy, output, 1, high in REQ and WRITE.
REQ-016 The block SHALL have port o_init_finished, output, 1, high in DONE; it is the init-complete level consumed by the IR register file stage.

Function
REQ-017 The block SHALL implement the states IDLE, REQ, WRITE and DONE, held in registered state; all outputs SHALL decode from registered state, count and data, with no combinational path from inputs to outputs.
REQ-018 IDLE or DONE with i_start=1: the block SHALL latch i_length into len, clear count to 0 and go to REQ, or go to DONE if i_length==0.
REQ-019 REQ: o_mem_req=1 and o_mem_addr=LOAD_BASE+count, truncated to DATA_WIDTH so that it wraps modulo 2^DATA_WIDTH; both SHALL be held stable until i_mem_ack.
REQ-020 REQ with i_mem_ack=1: the block SHALL capture i_mem_data into the data register and go to WRITE next cycle; if the acknowledge arrives in the first REQ cycle, that cycle is the last REQ cycle.
REQ-021 WRITE: o_ir_we=1 for exactly one cycle, with o_ir_addr=count and o_ir_data=captured data.
REQ-022 Leaving WRITE: if count==len-1 the block SHALL go to DONE; otherwise it SHALL increment count and go to REQ.
REQ-023 Throughput SHALL be a minimum of 2 cycles per word (REQ plus WRITE); a zero-wait load of N words SHALL take 2N cycles from the first REQ to DONE.
REQ-024 i_start in REQ or WRITE SHALL be ignored; len SHALL not change mid-load.
REQ-025 i_mem_ack outside REQ SHALL be ignored, with no capture and no state change.
REQ-026 i_length=2^IR_ADDR_WIDTH-1 SHALL load addresses 0..2^IR_ADDR_WIDTH-2 without count overflow.
REQ-027 DONE SHALL persist, with o_init_finished=1, until i_start or reset.
REQ-028 Outside WRITE, o_ir_we=0; o_ir_addr and o_ir_data SHALL hold their last values.
REQ-029 Outside REQ, o_mem_req=0; o_mem_addr SHALL hold its last value.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE, count=0, len=0 and data=0, so that o_mem_req=0, o_mem_addr=LOAD_BASE, o_ir_we=0, o_ir_addr=0, o_ir_data=0, o_busy=0 and o_init_finished=0 from the next cycle.
REQ-031 Reset asserted in REQ or WRITE SHALL abort the load with no further o_ir_we pulse; an acknowledge arriving in the reset cycle SHALL be discarded.
REQ-032 Reset SHALL take priority over i_start in the same cycle.

Verification
REQ-033 The bench SHALL drive i_start with i_length=3 and memory data 0xA1, 0xB2, 0xC3 acknowledged at zero wait, and check three o_ir_we pulses at addresses 0, 1, 2 with those data, plus o_init_finished=1 exactly 6 cycles after the first REQ.
REQ-034 The bench SHALL drive i_length=2 with the acknowledge delayed 4 cycles per word, and check that o_mem_req and o_mem_addr stay stable through the wait and that the two writes are correct.
REQ-035 The bench SHALL drive i_length=0, and check DONE the cycle after i_start, with no o_mem_req and no o_ir_we.
REQ-036 The bench SHALL set LOAD_BASE=0xFE and i_length=4, and check o_mem_addr sequence 0xFE, 0xFF, 0x00, 0x01 with o_ir_addr 0..3.
REQ-037 The bench SHALL drive rst_n=0 during the WRITE of word 1 of 3, and check no further writes, all outputs at reset values, and that a fresh i_start restarts from address 0.
REQ-038 The bench SHALL pulse i_start mid-load and drive i_mem_ack in WRITE, and check both are ignored, the load completes with the original length, and a new i_start in DONE clears o_init_finished and reloads.

Source files
------------

// File: rtl/ir_loader.sv
// Boot-time instruction loader: reads a block of words from memory and writes
// them into the instruction register file, then holds init-finished high.
module ir_loader #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned IR_ADDR_WIDTH = 8,
  parameter int unsigned LOAD_BASE     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [IR_ADDR_WIDTH-1:0] i_length,
  output logic                     o_mem_req,
  output logic [DATA_WIDTH-1:0]    o_mem_addr,
  input  logic                     i_mem_ack,
  input  logic [DATA_WIDTH-1:0]    i_mem_data,
  output logic                     o_ir_we,
  output logic [IR_ADDR_WIDTH-1:0] o_ir_addr,
  output logic [DATA_WIDTH-1:0]    o_ir_data,
  output logic                     o_busy,
  output logic                     o_init_finished
);

  // One-hot so each strobe is a flop output directly.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    REQ   = 4'b0010,
    WRITE = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t                   state;
  logic [IR_ADDR_WIDTH-1:0] count;
  logic [IR_ADDR_WIDTH-1:0] len;
  logic [IR_ADDR_WIDTH-1:0] ir_addr;
  logic [DATA_WIDTH-1:0]    data;
  logic [DATA_WIDTH-1:0]    mem_addr;
  logic                     last_word_c;

  // len is never zero while in WRITE, so len-1 cannot underflow there.
  assign last_word_c = (count == len - IR_ADDR_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      len      <= '0;
      data     <= '0;
      ir_addr  <= '0;
      mem_addr <= DATA_WIDTH'(LOAD_BASE);
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            len   <= i_length;
            count <= '0;
            if (i_length == '0) begin
              state <= DONE;
            end else begin
              mem_addr <= DATA_WIDTH'(LOAD_BASE);
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (i_mem_ack) begin
            data    <= i_mem_data;
            ir_addr <= count;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (last_word_c) begin
            state <= DONE;
          end else begin
            count    <= count + IR_ADDR_WIDTH'(1);
            // Address wraps modulo 2^DATA_WIDTH via the truncating cast.
            mem_addr <= DATA_WIDTH'(LOAD_BASE + 32'(count) + 32'd1);
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_mem_req       = state[1];
  assign o_ir_we         = state[2];
  assign o_init_finished = state[3];
  assign o_busy          = state[1] | state[2];
  assign o_mem_addr      = mem_addr;
  assign o_ir_addr       = ir_addr;
  assign o_ir_data       = data;

endmodule

// File: tb/tb_ir_loader.sv
// Scoreboard bench for ir_loader: port 0 uses LOAD_BASE=0, port 1 LOAD_BASE=0xFE.
module tb_ir_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  typedef struct {
    int         p;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          start, mreq, mack, we, busy, fin;
  logic [AW-1:0]       length;
  logic [1:0][DW-1:0]  maddr, mdata, idata;
  logic [1:0][AW-1:0]  iaddr;
  logic                stray_ack;
  int                  mem_wait;
  logic [DW-1:0]       mem [2][256];
  int                  wcnt [2];
  logic                prev_req [2];
  logic [DW-1:0]       prev_addr [2];
  int                  req_len [2];
  ev_t                 exp_ma[$];
  ev_t                 exp_wr[$];
  int                  n_checks = 0;
  int                  n_fail = 0;
  int                  cyc;

  always #5 clk = ~clk;

  ir_loader #(.DATA_WIDTH(DW), .IR_ADDR_WIDTH(AW), .LOAD_BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_length(length),
    .o_mem_req(mreq[0]), .o_mem_addr(maddr[0]), .i_mem_ack(mack[0]),
    .i_mem_data(mdata[0]), .o_ir_we(we[0]), .o_ir_addr(iaddr[0]),
    .o_ir_data(idata[0]), .o_busy(busy[0]), .o_init_finished(fin[0])
  );

  ir_loader #(.DATA_WIDTH(DW), .IR_ADDR_WIDTH(AW), .LOAD_BASE(8'hFE)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_length(length),
    .o_mem_req(mreq[1]), .o_mem_addr(maddr[1]), .i_mem_ack(mack[1]),
    .i_mem_data(mdata[1]), .o_ir_we(we[1]), .o_ir_addr(iaddr[1]),
    .o_ir_data(idata[1]), .o_busy(busy[1]), .o_init_finished(fin[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic push_req(input int p, input logic [7:0] a);
    ev_t e;
    e.p = p; e.a = a; e.d = 8'h00;
    exp_ma.push_back(e);
  endtask

  task automatic push_wr(input int p, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.p = p; e.a = a; e.d = d;
    exp_wr.push_back(e);
  endtask

  // Memory responder: acks after mem_wait extra REQ cycles; optional stray ack in WRITE.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (mreq[p]) begin
        if (wcnt[p] >= mem_wait) begin
          mack[p]  = 1'b1;
          mdata[p] = mem[p][maddr[p]];
          wcnt[p]  = 0;
        end else begin
          mack[p] = 1'b0;
          wcnt[p] = wcnt[p] + 1;
        end
      end else if (stray_ack && we[p]) begin
        mack[p]  = 1'b1;
        mdata[p] = 8'hEE;
        wcnt[p]  = 0;
      end else begin
        mack[p] = 1'b0;
        wcnt[p] = 0;
      end
    end
  end

  // Monitor: pops expected requests and writes as the DUTs present them.
  always @(negedge clk) begin
    ev_t e;
    for (int p = 0; p < 2; p++) begin
      if (mreq[p]) begin
        if (!prev_req[p]) begin
          req_len[p] = 1;
          if (exp_ma.size() == 0) fail_msg("unexpected_mem_req");
          else begin
            e = exp_ma.pop_front();
            chk("req_port", 32'(p), 32'(e.p));
            chk("mem_addr", 32'(maddr[p]), 32'(e.a));
          end
        end else begin
          req_len[p] = req_len[p] + 1;
          chk("mem_addr_hold", 32'(maddr[p]), 32'(prev_addr[p]));
        end
      end else if (prev_req[p]) begin
        chk("req_cycles", 32'(req_len[p]), 32'(mem_wait + 1));
      end
      if (we[p]) begin
        if (exp_wr.size() == 0) fail_msg("unexpected_ir_write");
        else begin
          e = exp_wr.pop_front();
          chk("wr_port", 32'(p), 32'(e.p));
          chk("ir_addr", 32'(iaddr[p]), 32'(e.a));
          chk("ir_data", 32'(idata[p]), 32'(e.d));
        end
      end
      prev_req[p]  = mreq[p];
      prev_addr[p] = maddr[p];
    end
  end

  task automatic start_load(input int p, input logic [7:0] len);
    @(negedge clk);
    length   = len;
    start[p] = 1'b1;
    @(negedge clk);
    start[p] = 1'b0;
  endtask

  task automatic wait_done(input int p, input int budget, output int cycles);
    cycles = 0;
    while (!fin[p] && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (!fin[p]) fail_msg("timeout_waiting_done");
  endtask

  task automatic wait_write(input int p, input logic [7:0] a, input int budget);
    int n = 0;
    while (!(we[p] && iaddr[p] == a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(we[p] && iaddr[p] == a)) fail_msg("timeout_waiting_write");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset(input int p, input logic [7:0] base);
    chk("rst_mem_req", 32'(mreq[p]), 32'(0));
    chk("rst_mem_addr", 32'(maddr[p]), 32'(base));
    chk("rst_ir_we", 32'(we[p]), 32'(0));
    chk("rst_ir_addr", 32'(iaddr[p]), 32'(0));
    chk("rst_ir_data", 32'(idata[p]), 32'(0));
    chk("rst_busy", 32'(busy[p]), 32'(0));
    chk("rst_init_finished", 32'(fin[p]), 32'(0));
  endtask

  task automatic check_drained();
    chk("pending_reqs", 32'(exp_ma.size()), 32'(0));
    chk("pending_writes", 32'(exp_wr.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[0][i] = 8'h00;
      mem[1][i] = 8'h00;
    end
    mem[0][0] = 8'hA1; mem[0][1] = 8'hB2; mem[0][2] = 8'hC3; mem[0][3] = 8'hD4;
    mem[1][8'hFE] = 8'h11; mem[1][8'hFF] = 8'h22; mem[1][8'h00] = 8'h33; mem[1][8'h01] = 8'h44;
    for (int p = 0; p < 2; p++) begin
      prev_req[p] = 1'b0; prev_addr[p] = 8'h00; req_len[p] = 0; wcnt[p] = 0;
    end
    rst_n = 1'b0; start = 2'b00; length = 8'h00; mack = 2'b00; mdata = '0;
    stray_ack = 1'b0; mem_wait = 0;
    repeat (3) @(negedge clk);
    check_reset(0, 8'h00);
    check_reset(1, 8'hFE);
    rst_n = 1'b1;

    // Three words, zero-wait memory.
    push_req(0, 8'h00); push_req(0, 8'h01); push_req(0, 8'h02);
    push_wr(0, 8'h00, 8'hA1); push_wr(0, 8'h01, 8'hB2); push_wr(0, 8'h02, 8'hC3);
    start_load(0, 8'd3);
    chk("t1_busy", 32'(busy[0]), 32'(1));
    wait_done(0, 50, cyc);
    chk("t1_done_latency", 32'(cyc), 32'(6));
    check_drained();
    chk("t1_ir_data_hold", 32'(idata[0]), 32'(8'hC3));
    chk("t1_mem_addr_hold", 32'(maddr[0]), 32'(8'h02));

    // Two words, 4 wait cycles per word.
    mem_wait = 4;
    push_req(0, 8'h00); push_req(0, 8'h01);
    push_wr(0, 8'h00, 8'hA1); push_wr(0, 8'h01, 8'hB2);
    start_load(0, 8'd2);
    wait_done(0, 100, cyc);
    chk("t2_done_latency", 32'(cyc), 32'(12));
    check_drained();
    mem_wait = 0;

    // Zero-length load goes straight to DONE.
    do_reset();
    check_reset(0, 8'h00);
    start_load(0, 8'd0);
    chk("t3_done", 32'(fin[0]), 32'(1));
    chk("t3_busy", 32'(busy[0]), 32'(0));
    repeat (3) @(negedge clk);
    chk("t3_done_persist", 32'(fin[0]), 32'(1));
    check_drained();

    // Non-zero base with address wrap.
    push_req(1, 8'hFE); push_req(1, 8'hFF); push_req(1, 8'h00); push_req(1, 8'h01);
    push_wr(1, 8'h00, 8'h11); push_wr(1, 8'h01, 8'h22);
    push_wr(1, 8'h02, 8'h33); push_wr(1, 8'h03, 8'h44);
    start_load(1, 8'd4);
    wait_done(1, 50, cyc);
    chk("t4_done_latency", 32'(cyc), 32'(8));
    check_drained();

    // Reset during WRITE of word 1 aborts, then a fresh load restarts at 0.
    do_reset();
    push_req(0, 8'h00); push_req(0, 8'h01);
    push_wr(0, 8'h00, 8'hA1); push_wr(0, 8'h01, 8'hB2);
    start_load(0, 8'd3);
    wait_write(0, 8'h01, 50);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset(0, 8'h00);
    repeat (4) @(negedge clk);
    chk("t5_idle_after_abort", 32'(busy[0]), 32'(0));
    check_drained();
    push_req(0, 8'h00); push_req(0, 8'h01); push_req(0, 8'h02);
    push_wr(0, 8'h00, 8'hA1); push_wr(0, 8'h01, 8'hB2); push_wr(0, 8'h02, 8'hC3);
    start_load(0, 8'd3);
    wait_done(0, 50, cyc);
    check_drained();

    // Mid-load start pulses and stray acks in WRITE are ignored.
    stray_ack = 1'b1;
    push_req(0, 8'h00); push_req(0, 8'h01); push_req(0, 8'h02);
    push_wr(0, 8'h00, 8'hA1); push_wr(0, 8'h01, 8'hB2); push_wr(0, 8'h02, 8'hC3);
    start_load(0, 8'd3);
    wait_write(0, 8'h00, 50);
    length = 8'd1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 50, cyc);
    check_drained();
    chk("t6_ir_data_no_stray", 32'(idata[0]), 32'(8'hC3));
    chk("t6_ir_addr_last", 32'(iaddr[0]), 32'(8'h02));
    push_req(0, 8'h00); push_req(0, 8'h01);
    push_wr(0, 8'h00, 8'hA1); push_wr(0, 8'h01, 8'hB2);
    start_load(0, 8'd2);
    chk("t6_restart_clears_done", 32'(fin[0]), 32'(0));
    chk("t6_restart_busy", 32'(busy[0]), 32'(1));
    wait_done(0, 50, cyc);
    check_drained();
    stray_ack = 1'b0;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
